pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline sequencing controller for the 5-stage pipelined datapath. Generates the capture-enable and flush (bubble-insert) controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. Detects load-use hazards, data-memory wait, and taken-branch redirects. Tracks per-stage valid bits, supports a drain-to-halt request, and keeps saturating stall and flush counters for the debug register file.

## Interface
Parameters:
- REG_AW, 5, register-file address width
- STALL_CW, 16, stall counter width
- FLUSH_CW, 8, flush counter width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs_addr, id_rt_addr  in  REG_AW  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction reads rs / rt
- ex_rd_addr  in  REG_AW  destination of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_busy  in  1  data memory not ready; the whole pipeline must freeze
- halt_req  in  1  level request to drain and halt
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  capture enables
- if_id_flush, id_ex_flush  out  1  load a bubble (all-zero/NOP) into that register
- valid_id, valid_ex, valid_mem, valid_wb  out  1  stage holds a real instruction
- halted  out  1  pipeline empty and stopped
- stall_cycles  out  STALL_CW  saturating count of cycles with pc_en=0 in RUN or DRAIN
- flush_count  out  FLUSH_CW  saturating count of taken-branch flushes

## Operation
- States: RUN, DRAIN, HALTED. Reset enters RUN.
- Hazard terms:
  - load_use = valid_ex & ex_mem_read & ex_rd_addr!=0 & ((id_uses_rs & rs==rd) | (id_uses_rt & rt==rd)) & valid_id.
  - redirect = valid_ex & ex_branch_taken.
- Priority, evaluated every cycle:
  1. mem_busy=1: all enables 0, no flushes, valid bits and counters hold. stall_cycles increments.
  2. redirect: all enables 1, if_id_flush=1, id_ex_flush=1, pc_en=1 (PC loads the target). flush_count increments. This holds in RUN and DRAIN.
  3. load_use: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1.
  4. Otherwise in RUN: all enables 1, no flush.
- Register 0 never causes a hazard. When redirect and load_use coincide, redirect wins.
- DRAIN, when no higher-priority rule applies: pc_en=0, if_id_flush=1, id_ex_en=ex_mem_en=mem_wb_en=1. The ID instruction issues, and the PC retains the not-yet-fetched address for resume.
- Transitions:
  - RUN→DRAIN when halt_req=1 and mem_busy=0.
  - DRAIN→HALTED when all four valid bits are 0.
  - HALTED→RUN when halt_req=0.
  - DRAIN→RUN if halt_req drops before empty.
- HALTED: all enables 0, no flushes, halted=1.
- Valid update, only when not frozen:
  - wb←mem; mem←ex.
  - ex←valid_id & ~load_use & ~redirect.
  - id←(pc_en & state==RUN) & ~redirect when if_id_en. id holds when if_id_en=0.
  - id←0 when if_id_flush=1.
- Counters saturate at all-ones and never wrap.

## Timing
- Enables and flushes are combinational from the current inputs, state and valid bits. They must settle within the same cycle the stage registers sample.
- State, valid bits, counters and halted are registered and update on the rising clk.
- Reset (asynchronous assert, synchronous release) sets:
  - state=RUN; all valid bits 0; counters 0; halted=0.
  - Combinational outputs then follow RUN with everything invalid: all enables 1, flushes 0.
- valid_id=1 from the first edge after reset release.
- Load-use costs exactly 1 bubble. A redirect costs 2 bubbles. mem_busy for N cycles costs N cycles.
- Drain from RUN with all stages full reaches halted=1 within 4 cycles plus any mem_busy cycles.
- Reset mid-drain or while frozen returns to RUN immediately.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, DRAIN, HALTED);
  - REG_AW default;
  - NOP/bubble encoding constant, shared with the stage registers.
- One sub-module, sat_counter (parameter width, inc, clear via rst_n), instantiated twice for stall_cycles and flush_count.
- Hazard compare stays inline.

## Test plan
- Reset release, no hazards for 5 cycles: valid_id..valid_wb become 1 on cycles 1..4; all enables 1; stall_cycles=0.
- Load to r5 in EX, ID reads rs=5: exactly 1 cycle with pc_en=0, if_id_en=0, id_ex_flush=1; valid_ex=0 next cycle; stall_cycles=1. Repeat with rd=0: no stall.
- ex_branch_taken with a coincident load_use: if_id_flush=id_ex_flush=1, pc_en=1; next cycle valid_id=valid_ex=0; flush_count=1.
- mem_busy held 3 cycles with the pipeline full: all enables 0 for 3 cycles, valid bits unchanged, stall_cycles=3; normal flow resumes on cycle 4.
- halt_req with the pipeline full: halted=1 within 4 cycles, pc_en=0 throughout; drop halt_req: RUN next cycle, valid_id=1 one cycle later.
- Drive 70000 stall cycles: stall_cycles saturates at 65535. Assert rst_n=0 mid-drain: everything returns to reset values asynchronously.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline sequencing controller
package pipe_ctrl_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef enum logic [1:0] {
    RUN    = ST_RUN,
    DRAIN  = ST_DRAIN,
    HALTED = ST_HALTED
  } state_e;

  // Bubble loaded into a stage register on flush; the stage registers use the same encoding.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stage enables, bubble flushes, valid tracking and drain-to-halt for the 5-stage pipe
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int STALL_CW = 16,
  parameter int FLUSH_CW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REG_AW-1:0]   id_rs_addr,
  input  logic [REG_AW-1:0]   id_rt_addr,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic [REG_AW-1:0]   ex_rd_addr,
  input  logic                ex_mem_read,
  input  logic                ex_branch_taken,
  input  logic                mem_busy,
  input  logic                halt_req,
  output logic                pc_en,
  output logic                if_id_en,
  output logic                id_ex_en,
  output logic                ex_mem_en,
  output logic                mem_wb_en,
  output logic                if_id_flush,
  output logic                id_ex_flush,
  output logic                valid_id,
  output logic                valid_ex,
  output logic                valid_mem,
  output logic                valid_wb,
  output logic                halted,
  output logic [STALL_CW-1:0] stall_cycles,
  output logic [FLUSH_CW-1:0] flush_count
);

  state_e state, state_nxt;
  logic   rs_hit, rt_hit, load_use, redirect;
  logic   v_id_nxt, v_ex_nxt, v_mem_nxt, v_wb_nxt;

  assign rs_hit   = id_uses_rs && (id_rs_addr == ex_rd_addr);
  assign rt_hit   = id_uses_rt && (id_rt_addr == ex_rd_addr);
  assign load_use = valid_ex && ex_mem_read && (ex_rd_addr != '0) && (rs_hit || rt_hit) && valid_id;
  assign redirect = valid_ex && ex_branch_taken;

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if ((state == HALTED) || mem_busy) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (state == DRAIN) begin
      // Let the ID instruction issue but stop fetching; PC keeps the resume address.
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  always_comb begin
    v_id_nxt  = valid_id;
    v_ex_nxt  = valid_ex;
    v_mem_nxt = valid_mem;
    v_wb_nxt  = valid_wb;
    if (!mem_busy) begin
      v_wb_nxt  = valid_mem;
      v_mem_nxt = valid_ex;
      v_ex_nxt  = valid_id && !load_use && !redirect;
      if (if_id_flush) begin
        v_id_nxt = 1'b0;
      end else if (if_id_en) begin
        v_id_nxt = pc_en && (state == RUN) && !redirect;
      end
    end
  end

  // Halting on the edge that empties the pipe keeps a full drain to four cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (halt_req && !mem_busy) state_nxt = DRAIN;
      DRAIN:   if (!halt_req) state_nxt = RUN;
               else if (!(v_id_nxt || v_ex_nxt || v_mem_nxt || v_wb_nxt)) state_nxt = HALTED;
      HALTED:  if (!halt_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      valid_id  <= 1'b0;
      valid_ex  <= 1'b0;
      valid_mem <= 1'b0;
      valid_wb  <= 1'b0;
    end else begin
      state     <= state_nxt;
      valid_id  <= v_id_nxt;
      valid_ex  <= v_ex_nxt;
      valid_mem <= v_mem_nxt;
      valid_wb  <= v_wb_nxt;
    end
  end

  assign halted = (state == HALTED);

  sat_counter #(.WIDTH(STALL_CW)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!pc_en && (state != HALTED)),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(FLUSH_CW)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect && !mem_busy && (state != HALTED)),
    .count (flush_count)
  );

endmodule
